// File: rtl/div_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_sched_pkg
//  Description : Shared types and helpers for the SRT divider issue/retire
//                controller (result record layout, latency mapping).
//  Revision    : 1.0 - initial release
// ============================================================================
package div_sched_pkg;

    // Default widths of the single-precision divider datapath
    localparam int c_def_sig_width = 23;
    localparam int c_def_tag_w     = 4;

    // One retired divide result at the default widths; the controller builds
    // a parameterised record with the same field order.
    typedef struct packed {
        logic [c_def_sig_width:0] quotient;
        logic                     guard;
        logic                     round;
        logic                     sticky;
        logic                     count;
        logic [c_def_tag_w-1:0]   tag;
        logic                     err;
    } div_res_t;

    // Number of divider registers that are actually enabled for a given
    // PIPE_STAGES setting (clamped to the supported 0..3 range).
    function automatic int pipe_latency(input int pipe_stages);
        if (pipe_stages <= 0) begin
            return 0;
        end else if (pipe_stages >= 3) begin
            return 3;
        end else begin
            return pipe_stages;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : div_skid_fifo
//  Description : 2-entry FIFO with parameterised payload and occupancy count.
//                Supports read and write in the same cycle, including when
//                full (the write reuses the slot being drained).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_rd;
    logic             w_wr;

    assign w_rd    = rd_en && (r_count != 2'd0);
    assign w_wr    = wr_en && ((r_count != 2'd2) || w_rd);
    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

    // Storage, pointers and occupancy; reset clears the data so an empty
    // buffer presents zeros on its head.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_rd) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_sig_sched.sv
`default_nettype none
// ============================================================================
//  Module      : div_sig_sched
//  Description : Issue/retire controller for the pipelined radix-4 SRT
//                significand divider. Tracks in-flight tags in a shadow
//                pipeline that moves with the divider enable and retires
//                results into a 2-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sig_sched
    import div_sched_pkg::*;
#(
    parameter int SIG_WIDTH   = 23,
    parameter int PIPE_STAGES = 3,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIG_WIDTH:0]   in_x,
    input  logic [SIG_WIDTH:0]   in_d,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [SIG_WIDTH:0]   dp_x,
    output logic [SIG_WIDTH:0]   dp_d,
    output logic                 dp_enable,
    output logic                 dp_resetn,
    input  logic [SIG_WIDTH:0]   dp_quotient,
    input  logic                 dp_guard,
    input  logic                 dp_round,
    input  logic                 dp_sticky,
    input  logic                 dp_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIG_WIDTH:0]   out_quotient,
    output logic                 out_guard,
    output logic                 out_round,
    output logic                 out_sticky,
    output logic                 out_count,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic                 busy
);

    localparam int c_lat = pipe_latency(PIPE_STAGES);

    typedef struct packed {
        logic [SIG_WIDTH:0] quotient;
        logic               guard;
        logic               round;
        logic               sticky;
        logic               count;
        logic [TAG_W-1:0]   tag;
        logic               err;
    } res_t;

    localparam int c_res_w = $bits(res_t);

    logic             w_in_err;
    logic             w_tail_valid;
    logic [TAG_W-1:0] w_tail_tag;
    logic             w_tail_err;
    logic             w_any_shadow;
    logic [1:0]       w_count;
    logic             w_wr_en;
    logic             w_rd_en;
    res_t             w_wr_res;
    res_t             w_rd_res;

    // An unnormalised divisor (leading bit clear) is flagged but still divided
    assign w_in_err  = ~in_d[SIG_WIDTH];
    assign dp_x      = in_valid ? in_x : '0;
    assign dp_d      = in_valid ? in_d : '0;
    assign dp_resetn = ~reset;

    // Freeze the divider only when a real result sits on its output and the
    // buffer cannot take it this cycle; a draining full buffer frees a slot.
    assign dp_enable = reset || !w_tail_valid || (w_count != 2'd2) || out_ready;
    assign in_ready  = dp_enable;

    generate
        if (c_lat == 0) begin : g_lat0
            // Combinational divider: the result pins belong to the input beat
            assign w_tail_valid = in_valid;
            assign w_tail_tag   = in_tag;
            assign w_tail_err   = w_in_err;
            assign w_any_shadow = 1'b0;
        end else begin : g_shadow
            logic [c_lat-1:0] r_sh_valid;
            logic [c_lat-1:0] r_sh_err;
            logic [TAG_W-1:0] r_sh_tag [c_lat];

            // Op descriptors shift in lock-step with the divider's registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sh_valid <= '0;
                    r_sh_err   <= '0;
                    for (int i = 0; i < c_lat; i++) begin
                        r_sh_tag[i] <= '0;
                    end
                end else if (dp_enable) begin
                    r_sh_valid[0] <= in_valid;
                    r_sh_err[0]   <= in_valid & w_in_err;
                    r_sh_tag[0]   <= in_valid ? in_tag : '0;
                    for (int i = 1; i < c_lat; i++) begin
                        r_sh_valid[i] <= r_sh_valid[i-1];
                        r_sh_err[i]   <= r_sh_err[i-1];
                        r_sh_tag[i]   <= r_sh_tag[i-1];
                    end
                end
            end

            assign w_tail_valid = r_sh_valid[c_lat-1];
            assign w_tail_tag   = r_sh_tag[c_lat-1];
            assign w_tail_err   = r_sh_err[c_lat-1];
            assign w_any_shadow = |r_sh_valid;
        end
    endgenerate

    assign w_wr_en = w_tail_valid && dp_enable;
    assign w_rd_en = out_valid && out_ready;

    assign w_wr_res.quotient = dp_quotient;
    assign w_wr_res.guard    = dp_guard;
    assign w_wr_res.round    = dp_round;
    assign w_wr_res.sticky   = dp_sticky;
    assign w_wr_res.count    = dp_count;
    assign w_wr_res.tag      = w_tail_tag;
    assign w_wr_res.err      = w_tail_err;

    div_skid_fifo #(
        .WIDTH (c_res_w)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_res),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_res),
        .count   (w_count)
    );

    assign out_valid    = (w_count != 2'd0);
    assign out_quotient = w_rd_res.quotient;
    assign out_guard    = w_rd_res.guard;
    assign out_round    = w_rd_res.round;
    assign out_sticky   = w_rd_res.sticky;
    assign out_count    = w_rd_res.count;
    assign out_tag      = w_rd_res.tag;
    assign out_err      = w_rd_res.err;
    assign busy         = w_any_shadow || out_valid;

endmodule
`default_nettype wire

// File: tb/tb_div_sig_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_div_sig_sched
//  Description : Self-checking bench for div_sig_sched. Four controllers
//                (PIPE_STAGES 0..3), each with a behavioural divider model,
//                share one request stream; a per-instance in-order scoreboard
//                checks every retired result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sig_sched;
    import div_sched_pkg::*;

    localparam int c_ninst = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [23:0] in_x = '0;
    logic [23:0] in_d = '0;
    logic [3:0]  in_tag = '0;

    logic [c_ninst-1:0] in_ready_v, dp_en_v, dp_rstn_v, out_valid_v, busy_v;
    logic [23:0]        dp_x_v [c_ninst];
    logic [23:0]        dp_d_v [c_ninst];
    div_res_t           out_res_v [c_ninst];

    typedef struct {
        div_res_t res;
        int       icyc;
        logic     strict;
    } exp_t;

    typedef struct {
        logic [23:0] x;
        logic [23:0] d;
        logic [3:0]  tag;
        div_res_t    exp;
    } vec_t;

    exp_t sb [c_ninst][$];
    int   pop3_cyc [$];
    int   pop3_tag [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic lat_strict = 1'b0;
    logic stall_watch = 1'b0;
    int   first_stall = -1;
    vec_t vt [6];

    // Behavioural divider: quotient = x/d scaled by 2^23, then guard/round
    // bits, sticky = nonzero remainder, count = quotient below one.
    function automatic logic [27:0] fdiv(input logic [23:0] x, input logic [23:0] d);
        logic [49:0] n, q, rm;
        if (d == 24'd0) return {24'hFFFFFF, 4'b0000};
        n  = 50'(x) << 25;
        q  = n / 50'(d);
        rm = n % 50'(d);
        return {q[25:2], q[1], q[0], (rm != 50'd0), (x < d)};
    endfunction

    function automatic div_res_t mk_res(input logic [23:0] x, input logic [23:0] d,
                                        input logic [3:0] tag);
        logic [27:0] f;
        div_res_t    r;
        f          = fdiv(x, d);
        r.quotient = f[27:4];
        r.guard    = f[3];
        r.round    = f[2];
        r.sticky   = f[1];
        r.count    = f[0];
        r.tag      = tag;
        r.err      = ~d[23];
        return r;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < c_ninst; gi++) begin : g_dut
        logic [27:0] w_f;
        logic [27:0] w_dres;
        logic [23:0] w_oq;
        logic        w_og, w_or, w_os, w_oc, w_oe;
        logic [3:0]  w_ot;

        assign w_f = fdiv(dp_x_v[gi], dp_d_v[gi]);

        if (gi == 0) begin : g_comb
            assign w_dres = w_f;
        end else begin : g_reg
            logic [27:0] st [gi];
            always @(posedge clk) begin
                if (dp_en_v[gi]) begin
                    st[0] <= w_f;
                    for (int k = 1; k < gi; k++) st[k] <= st[k-1];
                end
            end
            assign w_dres = st[gi-1];
        end

        div_sig_sched #(
            .SIG_WIDTH   (23),
            .PIPE_STAGES (gi),
            .TAG_W       (4)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid),
            .in_ready     (in_ready_v[gi]),
            .in_x         (in_x),
            .in_d         (in_d),
            .in_tag       (in_tag),
            .dp_x         (dp_x_v[gi]),
            .dp_d         (dp_d_v[gi]),
            .dp_enable    (dp_en_v[gi]),
            .dp_resetn    (dp_rstn_v[gi]),
            .dp_quotient  (w_dres[27:4]),
            .dp_guard     (w_dres[3]),
            .dp_round     (w_dres[2]),
            .dp_sticky    (w_dres[1]),
            .dp_count     (w_dres[0]),
            .out_valid    (out_valid_v[gi]),
            .out_ready    (out_ready),
            .out_quotient (w_oq),
            .out_guard    (w_og),
            .out_round    (w_or),
            .out_sticky   (w_os),
            .out_count    (w_oc),
            .out_tag      (w_ot),
            .out_err      (w_oe),
            .busy         (busy_v[gi])
        );

        assign out_res_v[gi] = {w_oq, w_og, w_or, w_os, w_oc, w_ot, w_oe};
    end

    // Scoreboard: expected results queue per instance in acceptance order
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            for (int k = 0; k < c_ninst; k++) sb[k].delete();
        end else begin
            for (int k = 0; k < c_ninst; k++) begin
                if (out_valid_v[k] && out_ready) begin
                    checks++;
                    if (sb[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result inst=%0d actual tag=%0h required no result",
                                 k, out_res_v[k].tag);
                    end else begin
                        e = sb[k].pop_front();
                        if (out_res_v[k] !== e.res) begin
                            errors++;
                            $display("FAIL result inst=%0d actual=%h required=%h", k, out_res_v[k], e.res);
                        end
                        if (e.strict && lat_strict) begin
                            checks++;
                            if (cyc - e.icyc != k + 1) begin
                                errors++;
                                $display("FAIL latency inst=%0d actual=%0d required=%0d",
                                         k, cyc - e.icyc, k + 1);
                            end
                        end
                    end
                    if (k == 3) begin
                        pop3_cyc.push_back(cyc);
                        pop3_tag.push_back(int'(out_res_v[3].tag));
                    end
                end
                if (in_valid && in_ready_v[k]) begin
                    e.res    = mk_res(in_x, in_d, in_tag);
                    e.icyc   = cyc;
                    e.strict = lat_strict;
                    sb[k].push_back(e);
                end
            end
            if (stall_watch && in_valid && !in_ready_v[3] && first_stall < 0) begin
                first_stall = cyc;
                checks++;
                if (!out_valid_v[3]) begin
                    errors++;
                    $display("FAIL stall_with_empty_buffer actual out_valid=0 required 1");
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one request and hold it until instance 3 accepts (bounded)
    task automatic send(input logic [23:0] x, input logic [23:0] d, input logic [3:0] tag,
                        output int acc);
        int n;
        in_valid = 1'b1;
        in_x     = x;
        in_d     = d;
        in_tag   = tag;
        n        = 0;
        acc      = -1;
        while (acc < 0 && n < 50) begin
            @(negedge clk);
            if (in_ready_v[3]) acc = cyc;
            n++;
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag=%0h actual not accepted required accepted", tag);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [23:0] rnd_norm();
        return {1'b1, 23'($urandom)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, first_acc, t0, b2b_low;

        vt[0] = '{24'h800000, 24'h800000, 4'd1, '{24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0}};
        vt[1] = '{24'hC00000, 24'h800000, 4'd2, '{24'hC00000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0}};
        vt[2] = '{24'h800000, 24'hC00000, 4'd3, '{24'h555555, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0}};
        vt[3] = '{24'h800000, 24'h400000, 4'd4, '{24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1}};
        vt[4] = '{24'hA00000, 24'h800000, 4'd5, '{24'hA00000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0}};
        vt[5] = '{24'hFFFFFF, 24'hFFFFFF, 4'd6, '{24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid_v), 64'h0);
        chk("rst_busy", 64'(busy_v), 64'h0);
        chk("rst_in_ready", 64'(in_ready_v), 64'hF);
        chk("rst_dp_enable", 64'(dp_en_v), 64'hF);
        chk("rst_dp_resetn", 64'(dp_rstn_v), 64'h0);
        chk("rst_out_data", 64'(out_res_v[3]), 64'h0);
        @(posedge clk); #1;
        reset      = 1'b0;
        lat_strict = 1'b1;
        @(negedge clk);
        chk("dp_resetn_run", 64'(dp_rstn_v), 64'hF);
        @(posedge clk); #1;

        // Table vectors: per-latency arrival cycle and full result on LAT=3
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_x     = vt[i].x;
            in_d     = vt[i].d;
            in_tag   = vt[i].tag;
            @(negedge clk);
            chk("vec_accept", 64'(in_ready_v[3]), 64'h1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_x     = '0;
            in_d     = '0;
            @(negedge clk);
            chk("vec_lat0_valid", 64'(out_valid_v[0]), 64'h1);
            chk("vec_lat0_tag", 64'(out_res_v[0].tag), 64'(vt[i].tag));
            @(negedge clk);
            chk("vec_lat1_valid", 64'(out_valid_v[1]), 64'h1);
            @(negedge clk);
            chk("vec_lat2_valid", 64'(out_valid_v[2]), 64'h1);
            chk("vec_lat3_early", 64'(out_valid_v[3]), 64'h0);
            @(negedge clk);
            chk("vec_lat3_valid", 64'(out_valid_v[3]), 64'h1);
            chk("vec_lat3_result", 64'(out_res_v[3]), 64'(vt[i].exp));
            @(posedge clk); #1;
        end

        // Back-to-back: 8 ops on consecutive cycles, 8 results on consecutive cycles
        pop3_cyc.delete();
        pop3_tag.delete();
        b2b_low = 0;
        t0      = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_x     = rnd_norm();
            in_d     = rnd_norm();
            in_tag   = 4'(i);
            @(negedge clk);
            if (!in_ready_v[3]) b2b_low++;
            if (i == 0) t0 = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_ready_low", 64'(b2b_low), 64'h0);
        chk("b2b_count", 64'(pop3_tag.size()), 64'd8);
        for (int i = 0; i < pop3_tag.size() && i < 8; i++) begin
            chk("b2b_tag", 64'(pop3_tag[i]), 64'(i));
            chk("b2b_cycle", 64'(pop3_cyc[i]), 64'(t0 + 4 + i));
        end

        // Backpressure: out_ready low for 10 cycles during a 6-op burst
        lat_strict = 1'b0;
        pop3_cyc.delete();
        pop3_tag.delete();
        first_stall = -1;
        first_acc   = -1;
        stall_watch = 1'b1;
        out_ready   = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(rnd_norm(), rnd_norm(), 4'(8 + i), acc);
                    if (i == 0) first_acc = acc;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (15) @(posedge clk);
        #1;
        stall_watch = 1'b0;
        chk("bp_stall_delay", 64'(first_stall - first_acc), 64'd5);
        chk("bp_count", 64'(pop3_tag.size()), 64'd6);
        for (int i = 0; i < pop3_tag.size() && i < 6; i++) begin
            chk("bp_tag_order", 64'(pop3_tag[i]), 64'(8 + i));
        end

        // Reset with 3 ops in flight and 2 buffered
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(rnd_norm(), rnd_norm(), 4'(i), acc);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy_v[3]), 64'h1);
        chk("pre_rst_valid", 64'(out_valid_v[3]), 64'h1);
        chk("pre_rst_stalled", 64'(dp_en_v[3]), 64'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_dp_resetn", 64'(dp_rstn_v[3]), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        pop3_cyc.delete();
        pop3_tag.delete();
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid_v), 64'h0);
        chk("post_rst_busy", 64'(busy_v), 64'h0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_stale", 64'(pop3_tag.size()), 64'd0);

        // Randomised traffic with bursty backpressure
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_x      = rnd_norm();
            in_d      = ($urandom_range(7) == 0) ? {1'b0, 23'($urandom)} : rnd_norm();
            in_tag    = 4'($urandom);
            out_ready = ((c % 100) < 20) ? 1'b0 : ($urandom_range(3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < c_ninst; k++) chk("rand_drained", 64'(sb[k].size()), 64'd0);
        chk("rand_idle_busy", 64'(busy_v), 64'h0);

        // Full-throughput random traffic: every op at exactly LAT+1
        @(posedge clk); #1;
        lat_strict = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_valid = ($urandom_range(4) != 0);
            in_x     = rnd_norm();
            in_d     = rnd_norm();
            in_tag   = 4'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < c_ninst; k++) chk("thru_drained", 64'(sb[k].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_sig_sched.md
# div_sig_sched

Issue/retire controller for the pipelined radix-4 SRT significand divider (`div_sigcalc`). It accepts divide requests over a valid/ready handshake and drives the divider's operand and enable pins. It tracks in-flight operations and their tags alongside the divider's register stages, and captures results into a 2-entry output skid buffer so downstream backpressure stalls the divider without losing data. It sits between the FP-divide front end (unpack/special-case) and the normalise/round stage.

## Interface
Parameters:
- `SIG_WIDTH`, 23: significand fraction width; operands/quotient are `SIG_WIDTH+1` bits.
- `PIPE_STAGES`, 3: value passed to the divider; 0..3.
- `TAG_W`, 4: width of the opaque request tag.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: request accepted when both `in_valid` and `in_ready` are high.
- `in_x`, in, `SIG_WIDTH+1`: dividend significand.
- `in_d`, in, `SIG_WIDTH+1`: divisor significand.
- `in_tag`, in, `TAG_W`: request tag.
- `dp_x`, out, `SIG_WIDTH+1`: divider dividend.
- `dp_d`, out, `SIG_WIDTH+1`: divider divisor.
- `dp_enable`, out, 1: divider pipeline enable.
- `dp_resetn`, out, 1: divider reset, equal to `~reset`.
- `dp_quotient`, in, `SIG_WIDTH+1`: divider quotient.
- `dp_guard`, `dp_round`, `dp_sticky`, `dp_count`, in, 1 each: divider status bits.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: downstream accepts the result.
- `out_quotient`, out, `SIG_WIDTH+1`: captured quotient.
- `out_guard`, `out_round`, `out_sticky`, `out_count`, out, 1 each: captured status bits.
- `out_tag`, out, `TAG_W`: tag of the result.
- `out_err`, out, 1: divisor was unnormalised.
- `busy`, out, 1: any op in flight or buffered.

## Operation
- Latency `LAT` depends on `PIPE_STAGES`: 0 → 0, 1 → 1, 2 → 2, 3 → 3 (number of divider registers enabled).
- Shadow pipeline: `LAT`-deep shift register of {valid, tag, err}. It advances only when `dp_enable`=1. Its tail describes the op currently on the `dp_*` result pins. For `LAT`=0 the tail is the current input beat.
- `dp_x`/`dp_d` come straight from `in_x`/`in_d`. When `in_valid`=0, drive zero and insert a bubble (valid=0) into the shadow pipeline.
- Stall rule: `dp_enable = !tail_valid || (skid_count < 2)`. Additionally, when `skid_count == 2` and `out_ready == 1`, the entry draining this cycle frees a slot, so `dp_enable` = 1.
- `in_ready` = `dp_enable`. Bubbles always advance.
- Skid buffer: 2-entry FIFO holding {quotient, g, r, s, count, tag, err}. It writes when `tail_valid && dp_enable`, reads when `out_valid && out_ready`, and supports simultaneous read and write.
- `out_*` present the head entry. `out_valid` = (`skid_count` != 0).
- Error: `err` = `!in_d[SIG_WIDTH]` at issue. The op still flows through the divider; the result is captured unchanged with `out_err`=1.
- `busy` = any shadow valid OR `skid_count` != 0.
- Results are returned strictly in issue order.

## Timing
- Reset, synchronous: shadow valids = 0, `skid_count` = 0, FIFO pointers = 0. Outputs: `out_valid` = 0, `busy` = 0, `out_*` data = 0, `in_ready` = 1, `dp_enable` = 1, `dp_resetn` = 0 while `reset` is high.
- Reset mid-operation discards all in-flight and buffered ops. No result appears after reset releases.
- Full throughput is one op per cycle when `out_ready` is held high.
- A request accepted at cycle t is visible on `out_*` at cycle t+`LAT`+1, through the registered skid buffer.
- Holding `out_ready`=0:
  - the buffer fills to 2;
  - the next valid tail forces `dp_enable`=0, freezing the divider and shadow register;
  - `in_ready`=0.
- The stall releases in the cycle `out_ready` returns, with no data lost or duplicated.
- Idle bubbles never block: a full buffer with `tail_valid`=0 still advances the pipeline.

## Structure
- Package `div_sched_pkg`:
  - typedef `div_res_t` for {quotient, guard, round, sticky, count, tag, err};
  - function `pipe_latency(PIPE_STAGES)`.
- Sub-module `div_skid_fifo`: 2-entry parameterised-payload FIFO with count output.
- The divider itself is instantiated by the parent, not inside this block.

## Test plan
- `PIPE_STAGES`=3, `out_ready`=1:
  - issue x=24'h800000, d=24'h800000, tag 1 → at t+4 `out_quotient`=24'h800000, g=r=s=0, `out_tag`=1;
  - then x=24'hC00000, d=24'h800000, tag 2 → 24'hC00000.
- Back-to-back: 8 requests, tags 0..7 on consecutive cycles → 8 results on consecutive cycles in tag order, `in_ready` never low.
- Backpressure: `out_ready`=0 for 10 cycles during a 6-op burst → `in_ready` falls after the buffer holds 2 and a third result is pending. On release, all 6 tags emerge once, in order.
- `PIPE_STAGES`=0: result appears one cycle after accept. `PIPE_STAGES`=1 and 2 give 2- and 3-cycle latency respectively.
- d=24'h400000 → `out_err`=1 for that tag only. Neighbouring ops have `out_err`=0.
- Assert `reset` for 1 cycle with 3 ops in flight and 2 buffered → `out_valid`=0 and `busy`=0 next cycle, with no stale results afterwards.
